// File: rtl/hi14a_tag_frame_decoder.sv
// ============================================================================
// Module   : hi14a_tag_frame_decoder
// Brief    : ISO14443-A tag response decoder (Manchester halves -> bytes).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hi14a_tag_frame_decoder #(
  parameter int HALF_SAMPLES   = 4,
  parameter int ONES_THRESHOLD = 2
) (
  input  logic       adc_clk,
  input  logic       reset,
  input  logic       sample_en,
  input  logic       curbit,
  output logic [7:0] data,
  output logic       parity_ok,
  output logic       coll,
  output logic       byte_valid,
  output logic       frame_active,
  output logic       frame_end,
  output logic [3:0] tail_bits,
  output logic [7:0] tail_data
);

  localparam int c_SAMP_W = (HALF_SAMPLES > 1) ? $clog2(HALF_SAMPLES) : 1;
  localparam int c_ONES_W = $clog2(HALF_SAMPLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SOF_A = 3'd1,
    ST_SOF_B = 3'd2,
    ST_RX_A  = 3'd3,
    ST_RX_B  = 3'd4
  } state_t;

  state_t              r_state, w_state_next;
  logic [c_SAMP_W-1:0] r_samp_cnt;
  logic [c_ONES_W-1:0] r_ones;
  logic                r_first;
  logic [8:0]          r_sr;
  logic [3:0]          r_bit_cnt;
  logic                r_coll_acc;

  logic [c_ONES_W-1:0] w_ones_now;
  logic                w_half_last, w_half_mod, w_half_done;
  logic                w_sof_ok, w_latch_first, w_bit_done, w_eof;
  logic [8:0]          w_sr_next;
  logic                w_new_coll;
  logic [3:0]          w_tail_shift;

  assign w_ones_now   = r_ones + c_ONES_W'(curbit);
  assign w_half_last  = (r_samp_cnt == c_SAMP_W'(HALF_SAMPLES - 1));
  assign w_half_mod   = (w_ones_now >= c_ONES_W'(ONES_THRESHOLD));
  assign w_half_done  = sample_en && w_half_last && (r_state != ST_IDLE);
  // The decoded bit equals the first-half value; (1,1) marks a collision.
  assign w_sr_next    = {r_first, r_sr[8:1]};
  assign w_new_coll   = r_first & w_half_mod;
  assign w_tail_shift = 4'd9 - r_bit_cnt;

  always_ff @(negedge adc_clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_sof_ok      = 1'b0;
    w_latch_first = 1'b0;
    w_bit_done    = 1'b0;
    w_eof         = 1'b0;
    case (r_state)
      ST_IDLE:  if (sample_en && curbit) w_state_next = ST_SOF_A;
      ST_SOF_A: if (w_half_done) w_state_next = w_half_mod ? ST_SOF_B : ST_IDLE;
      ST_SOF_B: if (w_half_done) begin
        if (w_half_mod) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_RX_A;
          w_sof_ok     = 1'b1;
        end
      end
      ST_RX_A:  if (w_half_done) begin
        w_latch_first = 1'b1;
        w_state_next  = ST_RX_B;
      end
      ST_RX_B:  if (w_half_done) begin
        if (!r_first && !w_half_mod) begin
          w_eof        = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_bit_done   = 1'b1;
          w_state_next = ST_RX_A;
        end
      end
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(negedge adc_clk) begin
    if (reset) begin
      r_samp_cnt   <= '0;
      r_ones       <= '0;
      r_first      <= 1'b0;
      r_sr         <= '0;
      r_bit_cnt    <= '0;
      r_coll_acc   <= 1'b0;
      data         <= '0;
      parity_ok    <= 1'b0;
      coll         <= 1'b0;
      byte_valid   <= 1'b0;
      frame_active <= 1'b0;
      frame_end    <= 1'b0;
      tail_bits    <= '0;
      tail_data    <= '0;
    end else begin
      byte_valid <= 1'b0;
      frame_end  <= 1'b0;

      if (sample_en) begin
        if (r_state == ST_IDLE) begin
          if (curbit) begin
            r_samp_cnt <= c_SAMP_W'(1);
            r_ones     <= c_ONES_W'(1);
          end
        end else if (w_half_last) begin
          r_samp_cnt <= '0;
          r_ones     <= '0;
        end else begin
          r_samp_cnt <= r_samp_cnt + c_SAMP_W'(1);
          r_ones     <= w_ones_now;
        end
      end

      if (w_latch_first) r_first <= w_half_mod;

      if (w_sof_ok) begin
        frame_active <= 1'b1;
        r_bit_cnt    <= '0;
        r_sr         <= '0;
        r_coll_acc   <= 1'b0;
      end

      if (w_bit_done) begin
        r_sr <= w_sr_next;
        // Ninth bit is the parity bit: odd parity over all nine is good.
        if (r_bit_cnt == 4'd8) begin
          data       <= w_sr_next[7:0];
          parity_ok  <= ^w_sr_next;
          coll       <= r_coll_acc | w_new_coll;
          byte_valid <= 1'b1;
          r_bit_cnt  <= '0;
          r_coll_acc <= 1'b0;
        end else begin
          r_bit_cnt  <= r_bit_cnt + 4'd1;
          r_coll_acc <= r_coll_acc | w_new_coll;
        end
      end

      if (w_eof) begin
        frame_end    <= 1'b1;
        frame_active <= 1'b0;
        tail_bits    <= r_bit_cnt;
        tail_data    <= 8'(r_sr >> w_tail_shift);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hi14a_tag_frame_decoder.sv
// ============================================================================
// Module   : tb_hi14a_tag_frame_decoder
// Brief    : Randomized self-checking bench for hi14a_tag_frame_decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hi14a_tag_frame_decoder;

  logic       adc_clk = 1'b0;
  logic       reset = 1'b1, sample_en = 1'b0, curbit = 1'b0;
  logic [7:0] data, tail_data;
  logic       parity_ok, coll, byte_valid, frame_active, frame_end;
  logic [3:0] tail_bits;

  always #5 adc_clk = ~adc_clk;

  hi14a_tag_frame_decoder #(.HALF_SAMPLES(4), .ONES_THRESHOLD(2)) dut (
    .adc_clk(adc_clk), .reset(reset), .sample_en(sample_en), .curbit(curbit),
    .data(data), .parity_ok(parity_ok), .coll(coll), .byte_valid(byte_valid),
    .frame_active(frame_active), .frame_end(frame_end),
    .tail_bits(tail_bits), .tail_data(tail_data)
  );

  int n_pass = 0, n_total = 0;
  bit noise = 1'b0;
  bit tx_bits[$];
  bit tx_coll[$];
  logic [31:0] obs_bytes[$];
  logic [31:0] obs_ends[$];
  int strobe_cnt = 0, nbytes_seen = 0, fa_rises = 0;
  logic prev_fa = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Outputs update on negedge; observe shortly after.
  always @(negedge adc_clk) begin
    #2;
    if (sample_en === 1'b1) strobe_cnt++;
    if (frame_active === 1'b1 && prev_fa !== 1'b1) begin
      strobe_cnt  = 0;
      nbytes_seen = 0;
      fa_rises++;
    end
    prev_fa = frame_active;
    if (byte_valid === 1'b1 || frame_end === 1'b1)
      check("pulse_excl", {31'b0, byte_valid & frame_end}, 32'd0);
    if (byte_valid === 1'b1) begin
      nbytes_seen++;
      check("byte_time", strobe_cnt, 72 * nbytes_seen);
      obs_bytes.push_back({22'b0, coll, parity_ok, data});
    end
    if (frame_end === 1'b1)
      obs_ends.push_back({strobe_cnt[19:0], tail_bits, tail_data});
  end

  task automatic strobe(input logic b);
    @(posedge adc_clk); sample_en = 1'b1; curbit = b;
    @(posedge adc_clk); sample_en = 1'b0; curbit = 1'b0;
    repeat (14) @(posedge adc_clk);
  endtask

  task automatic half(input logic m);
    int f;
    f = noise ? int'($urandom_range(0, 3)) : -1;
    for (int i = 0; i < 4; i++) strobe((i == f) ? ~m : m);
  endtask

  task automatic send_sof();
    for (int i = 0; i < 4; i++) strobe(1'b1);
    half(1'b0);
  endtask

  task automatic send_bit(input int i);
    if (tx_coll[i])     begin half(1'b1); half(1'b1); end
    else if (tx_bits[i]) begin half(1'b1); half(1'b0); end
    else                begin half(1'b0); half(1'b1); end
  endtask

  task automatic send_frame();
    send_sof();
    for (int i = 0; i < tx_bits.size(); i++) send_bit(i);
    half(1'b0); half(1'b0);
    repeat (4) strobe(1'b0);
  endtask

  task automatic push_bit(input bit b, input bit c);
    tx_bits.push_back(b | c);
    tx_coll.push_back(c);
  endtask

  task automatic push_byte(input logic [7:0] d, input logic p, input logic [8:0] cmask);
    for (int k = 0; k < 8; k++) push_bit(d[k], cmask[k]);
    push_bit(p, cmask[8]);
  endtask

  task automatic clear_all();
    tx_bits.delete(); tx_coll.delete(); obs_bytes.delete(); obs_ends.delete();
  endtask

  // Reference: every nine received bits form data+parity, the rest is the tail.
  task automatic check_frame();
    int nfull, ntail;
    logic [7:0] et;
    nfull = tx_bits.size() / 9;
    ntail = tx_bits.size() % 9;
    check("n_bytes", obs_bytes.size(), nfull);
    for (int b = 0; b < nfull; b++) begin
      logic [7:0] ed;
      bit ep, ec;
      ed = '0; ep = 0; ec = 0;
      for (int k = 0; k < 9; k++) begin
        if (k < 8) ed[k] = tx_bits[9*b + k];
        ep ^= tx_bits[9*b + k];
        ec |= tx_coll[9*b + k];
      end
      if (b < obs_bytes.size()) begin
        check("data", obs_bytes[b][7:0], ed);
        check("parity_ok", obs_bytes[b][8], ep);
        check("coll", obs_bytes[b][9], ec);
      end
    end
    et = '0;
    for (int k = 0; k < ntail; k++) et[k] = tx_bits[9*nfull + k];
    check("n_ends", obs_ends.size(), 1);
    if (obs_ends.size() > 0) begin
      check("tail_bits", obs_ends[0][11:8], ntail);
      check("tail_data", obs_ends[0][7:0], et);
      check("end_time", obs_ends[0][31:12], 8 * tx_bits.size() + 8);
    end
    check("fa_after", frame_active, 0);
    clear_all();
  endtask

  function automatic logic [31:0] all_outs();
    return {7'b0, data, parity_ok, coll, byte_valid, frame_active, frame_end, tail_bits, tail_data};
  endfunction

  initial begin
    int fa0, nb, nt;
    // Reset held while strobes keep arriving
    repeat (4) strobe(1'b0);
    check("reset_outs", all_outs(), 0);
    reset = 1'b0;
    repeat (4) strobe(1'b0);
    check("idle_outs", all_outs(), 0);

    clear_all(); push_byte(8'h26, 1'b0, 9'h000); send_frame(); check_frame();
    clear_all(); push_byte(8'h26, 1'b1, 9'h000); send_frame(); check_frame();
    clear_all(); push_byte(8'h26, 1'b0, 9'h008); send_frame(); check_frame();
    clear_all(); push_byte(8'h26, 1'b0, 9'h000);
    push_bit(1, 0); push_bit(0, 0); push_bit(1, 0);
    send_frame(); check_frame();

    // Single-sample glitch
    clear_all(); fa0 = fa_rises;
    strobe(1'b1); repeat (11) strobe(1'b0);
    check("glitch_fa", fa_rises - fa0, 0);
    check("glitch_ev", obs_bytes.size() + obs_ends.size(), 0);

    // SOF with modulated second half
    fa0 = fa_rises;
    for (int i = 0; i < 4; i++) strobe(1'b1);
    half(1'b1); repeat (8) strobe(1'b0);
    check("badsof_fa", fa_rises - fa0, 0);
    check("badsof_ev", obs_bytes.size() + obs_ends.size(), 0);

    // Reset at bit 5, then a clean noisy frame
    clear_all(); push_byte(8'hA5, 1'b1, 9'h000);
    send_sof();
    for (int i = 0; i < 5; i++) send_bit(i);
    @(posedge adc_clk); reset = 1'b1;
    repeat (3) @(posedge adc_clk);
    check("midrst_outs", all_outs(), 0);
    reset = 1'b0;
    repeat (4) strobe(1'b0);
    check("midrst_ev", obs_bytes.size() + obs_ends.size(), 0);
    clear_all(); noise = 1'b1;
    push_byte(8'h93, 1'b1, 9'h000); send_frame(); check_frame();

    for (int r = 0; r < 10; r++) begin
      clear_all();
      noise = 1'($urandom_range(0, 1));
      nb = $urandom_range(0, 2);
      for (int b = 0; b < nb; b++) begin
        logic [8:0] cm;
        cm = '0;
        for (int k = 0; k < 9; k++) cm[k] = ($urandom_range(0, 7) == 0);
        push_byte(8'($urandom), 1'($urandom), cm);
      end
      nt = $urandom_range(0, 8);
      for (int k = 0; k < nt; k++) push_bit(1'($urandom), ($urandom_range(0, 7) == 0));
      send_frame();
      check_frame();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
